// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin tie break, no preemption and a
// stalled-strobe timeout that forces an error back to the owning master.
module wb_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              m_cyc_i,
  input  logic [1:0]              m_stb_i,
  input  logic [1:0]              m_we_i,
  input  logic [2*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [15:0]             m_dat_i,
  input  logic [5:0]              m_cti_i,
  input  logic [3:0]              m_bte_i,
  output logic [1:0]              m_ack_o,
  output logic [1:0]              m_err_o,
  output logic [1:0]              m_rty_o,
  output logic [7:0]              m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [7:0]              s_dat_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [7:0]              s_dat_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  // A zero timeout disables the counter but still needs a legal width.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, TOERR, HOLD} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               own_cyc, own_stb, other_cyc, s_resp, to_hit;

  assign own_cyc   = m_cyc_i[owner_q];
  assign own_stb   = m_stb_i[owner_q];
  assign other_cyc = m_cyc_i[~owner_q];
  assign s_resp    = s_ack_i | s_err_i | s_rty_i;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign to_hit    = (TIMEOUT_CYCLES > 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (m_cyc_i == 2'b11) begin
          owner_d = ~last_q;
          state_d = BUSY;
        end else if (m_cyc_i[0]) begin
          owner_d = 1'b0;
          state_d = BUSY;
        end else if (m_cyc_i[1]) begin
          owner_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          // Release hands straight over to a waiting master without an idle cycle.
          last_d = owner_q;
          if (other_cyc) begin
            owner_d = ~owner_q;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end else if (own_stb && !s_resp) begin
          if (to_hit) state_d = TOERR;
          else        cnt_d   = cnt_inc;
        end
      end
      TOERR: state_d = HOLD;
      HOLD: begin
        if (!own_cyc) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m_ack_o   = 2'b00;
    m_err_o   = 2'b00;
    m_rty_o   = 2'b00;
    m_dat_o   = s_dat_i;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    if (state_q != IDLE) grant_o = owner_q ? 2'b10 : 2'b01;
    case (state_q)
      BUSY: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_we_o  = m_we_i[owner_q];
        s_adr_o = owner_q ? m_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_adr_i[ADDR_WIDTH-1:0];
        s_dat_o = owner_q ? m_dat_i[15:8] : m_dat_i[7:0];
        s_cti_o = owner_q ? m_cti_i[5:3]  : m_cti_i[2:0];
        s_bte_o = owner_q ? m_bte_i[3:2]  : m_bte_i[1:0];
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i;
        m_rty_o[owner_q] = s_rty_i;
      end
      TOERR: begin
        m_err_o[owner_q] = 1'b1;
        timeout_o        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (TIMEOUT_CYCLES=4) plus a
// hand-written reset-during-timeout sequence.
module tb_wb_arbiter;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [2*AW-1:0] m_adr;
  logic [15:0]   m_dat;
  logic [5:0]    m_cti;
  logic [3:0]    m_bte;
  logic [1:0]    m_ack, m_err, m_rty;
  logic [7:0]    m_dat_o;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [7:0]    s_dat_o;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic          s_ack, s_err, s_rty;
  logic [7:0]    s_dat;
  logic [1:0]    grant;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_dat_i(m_dat), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat_o), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
    .grant_o(grant), .timeout_o(timeout)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] cyc, stb;
    logic [2:0] cti1;
    logic       ack, err, rty;
    logic [7:0] sdat;
    logic [1:0] e_grant, e_ack, e_err, e_rty;
    logic       e_scyc, e_sstb, e_to;
    logic [7:0] e_sdato;
    logic [2:0] e_scti;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                     input logic [2:0] cti1, input logic ack, input logic err,
                     input logic rty, input logic [7:0] sdat,
                     input logic [1:0] g, input logic [1:0] ea, input logic [1:0] ee,
                     input logic [1:0] er, input logic ec, input logic es,
                     input logic et, input logic [7:0] edo, input logic [2:0] ecti);
    vec_t v;
    v.rst_n = r; v.cyc = cyc; v.stb = stb; v.cti1 = cti1;
    v.ack = ack; v.err = err; v.rty = rty; v.sdat = sdat;
    v.e_grant = g; v.e_ack = ea; v.e_err = ee; v.e_rty = er;
    v.e_scyc = ec; v.e_sstb = es; v.e_to = et; v.e_sdato = edo; v.e_scti = ecti;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                       input logic [2:0] cti1, input logic ack, input logic err,
                       input logic rty, input logic [7:0] sdat);
    rst_n = r; m_cyc = cyc; m_stb = stb; m_cti = {cti1, 3'b000};
    s_ack = ack; s_err = err; s_rty = rty; s_dat = sdat;
  endtask

  initial begin
    int found;
    m_we  = 2'b01;
    m_adr = {24'h000200, 24'h000100};
    m_dat = {8'h22, 8'h11};
    m_bte = 4'b0110;
    drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);

    //   rst cyc    stb    cti1    ack err rty sdat  | grant  ack    err    rty  scyc sstb to sdato  scti
    add(0, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h5A, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'b000);
    add(1, 2'b11, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b11, 2'b01, 3'b000, 1, 0, 0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 0, 8'h11, 3'b000);
    add(1, 2'b10, 2'b10, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h11, 3'bx);
    add(1, 2'b10, 2'b10, 3'b000, 1, 0, 0, 8'hA5, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b000);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h22, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 1, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    // m1 burst with m0 arriving at beat 2
    add(1, 2'b10, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b10, 2'b10, 3'b010, 1, 0, 0, 8'h01, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b010);
    add(1, 2'b11, 2'b11, 3'b010, 1, 0, 0, 8'h02, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b010);
    add(1, 2'b11, 2'b11, 3'b010, 1, 0, 0, 8'h03, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b010);
    add(1, 2'b11, 2'b11, 3'b111, 1, 0, 0, 8'h04, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b111);
    add(1, 2'b01, 2'b01, 3'b000, 0, 0, 0, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h22, 3'bx);
    add(1, 2'b01, 2'b00, 3'b000, 0, 1, 0, 8'h00, 2'b01, 2'b00, 2'b01, 2'b00, 1, 0, 0, 8'h11, 3'b000);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    // m0 stalls into the timeout
    add(1, 2'b01, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    for (int i = 0; i < 4; i++)
      add(1, 2'b01, 2'b01, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, 8'h11, 3'bx);
    add(1, 2'b01, 2'b01, 3'b000, 1, 0, 0, 8'h00, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 1, 8'hxx, 3'bx);
    add(1, 2'b01, 2'b01, 3'b000, 1, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    // ack lands on the cycle that would have timed out
    add(1, 2'b01, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    for (int i = 0; i < 3; i++)
      add(1, 2'b01, 2'b01, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, 8'h11, 3'bx);
    add(1, 2'b01, 2'b01, 3'b000, 1, 0, 0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 0, 8'h11, 3'bx);
    add(1, 2'b01, 2'b01, 3'b000, 0, 0, 1, 8'h00, 2'b01, 2'b00, 2'b00, 2'b01, 1, 1, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    // reset in the middle of an m1 burst
    add(1, 2'b10, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b10, 2'b10, 3'b010, 1, 0, 0, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b010);
    add(0, 2'b11, 2'b11, 3'b010, 1, 0, 0, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0, 8'h22, 3'b010);
    add(1, 2'b11, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b11, 2'b11, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    // tie with m0 as last owner goes to m1
    add(1, 2'b11, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);
    add(1, 2'b11, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 8'h22, 3'bx);
    add(1, 2'b01, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h22, 3'bx);
    add(1, 2'b01, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h11, 3'bx);
    add(1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h00, 3'bx);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rst_n, vecs[i].cyc, vecs[i].stb, vecs[i].cti1,
            vecs[i].ack, vecs[i].err, vecs[i].rty, vecs[i].sdat);
      @(negedge clk);
      check($sformatf("v%0d grant", i), grant, vecs[i].e_grant);
      check($sformatf("v%0d m_ack", i), m_ack, vecs[i].e_ack);
      check($sformatf("v%0d m_err", i), m_err, vecs[i].e_err);
      check($sformatf("v%0d m_rty", i), m_rty, vecs[i].e_rty);
      check($sformatf("v%0d s_cyc", i), s_cyc, vecs[i].e_scyc);
      check($sformatf("v%0d s_stb", i), s_stb, vecs[i].e_sstb);
      check($sformatf("v%0d timeout", i), timeout, vecs[i].e_to);
      check($sformatf("v%0d m_dat_o", i), m_dat_o, vecs[i].sdat);
      if (!$isunknown(vecs[i].e_sdato))
        check($sformatf("v%0d s_dat_o", i), s_dat_o, vecs[i].e_sdato);
      if (!$isunknown(vecs[i].e_scti))
        check($sformatf("v%0d s_cti", i), s_cti, vecs[i].e_scti);
    end

    // Reset asserted while the timeout error is being reported.
    @(posedge clk); #1;
    drive(1'b1, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00);
    found = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("seq s_we", s_we, 1'b1);
        check("seq s_adr", s_adr, 24'h000100);
      end
      if (timeout) begin
        found = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("seq timeout cycle", found, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("seq rst grant", grant, 2'b00);
    check("seq rst timeout", timeout, 1'b0);
    check("seq rst m_err", m_err, 2'b00);
    check("seq rst s_cyc", s_cyc, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, address width of all masters and the slave.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-strobe cycles before forced error; 0 disables the timeout.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have port m_cyc_i, input, 2, master cycle requests; bit n = master n.
REQ-006 SHALL have port m_stb_i, input, 2, master strobes.
REQ-007 SHALL have port m_we_i, input, 2, master write enables.
REQ-008 SHALL have port m_adr_i, input, 2*ADDR_WIDTH, master addresses; master n in slice [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port m_dat_i, input, 16, master write data; master n in [n*8 +: 8].
REQ-010 SHALL have port m_cti_i, input, 6, master CTI; master n in [n*3 +: 3].
REQ-011 SHALL have port m_bte_i, input, 4, master BTE; master n in [n*2 +: 2].
REQ-012 SHALL have port m_ack_o, output, 2, per-master acknowledge.
REQ-013 SHALL have port m_err_o, output, 2, per-master error.
REQ-014 SHALL have port m_rty_o, output, 2, per-master retry.
REQ-015 SHALL have port m_dat_o, output, 8, read data broadcast to both masters.
REQ-016 SHALL have ports s_cyc_o, s_stb_o, s_we_o, output, 1 each, slave cycle/strobe/write.
REQ-017 SHALL have ports s_adr_o (ADDR_WIDTH), s_dat_o (8), s_cti_o (3), s_bte_o (2), output, slave address/data/burst fields.
REQ-018 SHALL have ports s_ack_i, s_err_i, s_rty_i, input, 1 each, slave responses.
REQ-019 SHALL have port s_dat_i, input, 8, slave read data.
REQ-020 SHALL have port grant_o, output, 2, one-hot current owner; 00 when idle.
REQ-021 SHALL have port timeout_o, output, 1, one-cycle pulse on forced timeout.

Function
REQ-022 SHALL implement the FSM IDLE, BUSY, TOERR, HOLD, with an owner register and a last-owner register.
REQ-023 IDLE: all s_* outputs 0; grant_o=00.
REQ-024 IDLE, one m_cyc_i bit set: owner=that master, enter BUSY next cycle.
REQ-025 IDLE, both bits set: owner=master != last-owner (round-robin), enter BUSY next cycle.
REQ-026 BUSY: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_cti_o/s_bte_o combinationally equal the owner's inputs.
REQ-027 BUSY: m_ack_o/m_err_o/m_rty_o[owner] combinationally equal s_ack_i/s_err_i/s_rty_i; non-owner bits 0.
REQ-028 m_dat_o SHALL equal s_dat_i at all times.
REQ-029 Grant is held while m_cyc_i[owner]=1, including across CTI 010 bursts; no preemption.
REQ-030 BUSY, m_cyc_i[owner]=0: last-owner<=owner; re-arbitrate that edge per REQ-024/025 using the other master's request; enter BUSY with new owner or IDLE; no dead cycle on handoff.
REQ-031 Timeout counter, width $clog2(TIMEOUT_CYCLES+1): increments each BUSY cycle with s_stb_o=1 and no slave response; clears on any response, s_stb_o=0, or leaving BUSY.
REQ-032 Counter reaching TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): enter TOERR.
REQ-033 TOERR, one cycle: m_err_o[owner]=1, timeout_o=1, s_cyc_o=s_stb_o=0; then HOLD.
REQ-034 HOLD: s_* outputs 0, grant_o unchanged; when m_cyc_i[owner]=0, last-owner<=owner, enter IDLE.
REQ-035 Slave response in the same cycle the counter would reach TIMEOUT_CYCLES: response wins, counter clears, no TOERR.
REQ-036 Slave responses in IDLE/TOERR/HOLD SHALL be ignored (all m_ack/err/rty 0 except REQ-033).

Reset
REQ-037 rst_ni=0 at a clock edge: state IDLE, grant_o=00, last-owner=1 (master 0 wins first tie), counter 0, timeout_o 0, all s_* outputs 0, all m_ack/err/rty 0 -- including mid-burst or mid-timeout.

Verification
REQ-038 Both m_cyc_i rise together after reset -> grant_o=01 next cycle; m0 releases -> grant_o=10 next edge, no idle cycle.
REQ-039 m1 runs 4-beat burst (CTI 010,010,010,111), m0 requests at beat 2 -> grant stays 10 through all 4 acks; m0 granted after m1 drops cyc.
REQ-040 TIMEOUT_CYCLES=4, owner m0 strobes, slave silent -> after 4 stalled cycles m_err_o=01 and timeout_o=1 for one cycle, s_cyc_o=0; m0 drops cyc -> IDLE.
REQ-041 TIMEOUT_CYCLES=4, s_ack_i on 4th stalled cycle -> m_ack_o=01, no timeout_o, transfer continues.
REQ-042 rst_ni low during m1 burst -> next cycle grant_o=00, s_cyc_o=0; after release with both requesting -> grant_o=01.
REQ-043 Owner m1 read, s_dat_i=8'hA5 with s_ack_i -> m_dat_o=8'hA5, m_ack_o=10, m_ack_o[0]=0.
